// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan controller.
package pattern_scan_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_PAT_W  = 7;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A length of 0 (or anything beyond the history width) means the full width.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned pat_w);
        return (len == 0 || len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// History register, fill counter and length-masked comparator for the serial matcher.
module pattern_match_core
    import pattern_scan_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             match
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_next;
    int unsigned      l_eff;

    // Match is judged on the history as it will look after this shift.
    always_comb begin
        hist_next = {hist[PAT_W-2:0], bit_in};
        fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
        l_eff     = eff_len(32'(len), PAT_W);
        mask      = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < l_eff);
        end
        match = shift_en && (32'(fill_next) >= l_eff) &&
                (((hist_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word-to-serial pattern scan controller: handshake, run sequencing and match counting.
// Optional abort input enabled by defining PATTERN_SCAN_ABORT_EN.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PAT_W  = DEF_PAT_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]           cfg_words,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
`ifdef PATTERN_SCAN_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       in_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       match_pulse,
    output logic [CNT_W-1:0]           match_cnt
);

    localparam int unsigned LEN_W = $clog2(PAT_W + 1);
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]        state;
    logic [PAT_W-1:0]  pat_r;
    logic [LEN_W-1:0]  len_r;
    logic [CNT_W-1:0]  words_r;
    logic [CNT_W-1:0]  words_src;
    logic [CNT_W-1:0]  word_cnt;
    logic [DATA_W-1:0] word_r;
    logic [IDX_W-1:0]  bit_idx;
    logic              abort_i;
    logic              run_start;
    logic              shift_en;
    logic              core_match;

`ifdef PATTERN_SCAN_ABORT_EN
    assign abort_i = abort && (state == ST_LOAD || state == ST_SHIFT);
`else
    assign abort_i = 1'b0;
`endif

    assign run_start = (state == ST_IDLE) && start;
    assign shift_en  = (state == ST_SHIFT) && !abort_i;
    // A config write on the start edge applies to the run being started.
    assign words_src = cfg_we ? cfg_words : words_r;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    pattern_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (run_start),
        .bit_in   (word_r[bit_idx]),
        .pattern  (pat_r),
        .len      (len_r),
        .match    (core_match)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat_r       <= '0;
            len_r       <= '0;
            words_r     <= '0;
            word_cnt    <= '0;
            word_r      <= '0;
            bit_idx     <= '0;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
        end else begin
            match_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_we) begin
                        pat_r   <= cfg_pattern;
                        len_r   <= cfg_len;
                        words_r <= cfg_words;
                    end
                    if (start) begin
                        match_cnt <= '0;
                        word_cnt  <= words_src;
                        state     <= (words_src == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if (in_valid) begin
                        word_r  <= in_data;
                        bit_idx <= IDX_W'(DATA_W - 1);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else begin
                        if (core_match) begin
                            match_pulse <= 1'b1;
                            if (match_cnt != '1) begin
                                match_cnt <= match_cnt + CNT_W'(1);
                            end
                        end
                        bit_idx <= bit_idx - IDX_W'(1);
                        if (bit_idx == '0) begin
                            word_cnt <= word_cnt - CNT_W'(1);
                            state    <= (word_cnt == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed table, hand sequences and random runs.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [6:0] cfg_pattern = '0;
    logic [2:0] cfg_len = '0;
    logic [7:0] cfg_words = '0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       match_pulse;
    logic [7:0] match_cnt;
`ifdef PATTERN_SCAN_ABORT_EN
    logic       abort = 1'b0;
`endif

    pattern_scan_ctrl #(
        .DATA_W (8),
        .PAT_W  (7),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_words   (cfg_words),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
`ifdef PATTERN_SCAN_ABORT_EN
        .abort       (abort),
`endif
        .in_ready    (in_ready),
        .busy        (busy),
        .done        (done),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference configuration as the controller should hold it.
    logic [6:0] cur_pat = '0;
    logic [2:0] cur_len = '0;
    logic [7:0] cur_words = '0;

    logic [7:0] wbuf [64];
    int         dbuf [64];
    bit         mh [$];

    typedef struct {
        bit         ready;
        bit         busy;
        bit         done;
        bit         pulse;
        bit         valid;
        int         cnt;
        logic [7:0] data;
    } cyc_t;
    cyc_t tr [$];

    typedef struct {
        logic [6:0] pat;
        logic [2:0] len;
        logic [7:0] nw;
        logic [7:0] w0;
        logic [7:0] w1;
        int         dly;
        int         exp_cnt;
    } vec_t;
    vec_t vec [5];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d t=%0t", nm, cyc, act, exp, $time);
        end
    endtask

    // Newest bit is compared with pattern[0], the oldest in the window with pattern[L-1].
    function automatic bit win_match(input int L);
        int n;
        n = mh.size();
        if (n < L) return 1'b0;
        for (int k = 0; k < L; k++) begin
            if (mh[n-1-k] != cur_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected per-cycle view of the outputs, starting with the cycle after the start edge.
    task automatic build_trace();
        int L;
        int cnt;
        bit pm;
        bit m;
        L = (cur_len == 0) ? 7 : int'(cur_len);
        tr.delete();
        mh.delete();
        cnt = 0;
        pm = 1'b0;
        for (int w = 0; w < int'(cur_words); w++) begin
            for (int i = 0; i <= dbuf[w]; i++) begin
                tr.push_back('{ready: 1'b1, busy: 1'b1, done: 1'b0, pulse: pm,
                               valid: (i == dbuf[w]), cnt: cnt,
                               data: (i == dbuf[w]) ? wbuf[w] : 8'($urandom)});
                pm = 1'b0;
            end
            for (int b = 7; b >= 0; b--) begin
                tr.push_back('{ready: 1'b0, busy: 1'b1, done: 1'b0, pulse: pm,
                               valid: 1'($urandom), cnt: cnt, data: 8'($urandom)});
                mh.push_back(wbuf[w][b]);
                m = win_match(L);
                if (m && cnt < 255) cnt++;
                pm = m;
            end
        end
        tr.push_back('{ready: 1'b0, busy: 1'b1, done: 1'b1, pulse: pm,
                       valid: 1'b0, cnt: cnt, data: 8'h00});
        tr.push_back('{ready: 1'b0, busy: 1'b0, done: 1'b0, pulse: 1'b0,
                       valid: 1'b0, cnt: cnt, data: 8'h00});
    endtask

    task automatic run(input bit use_we, input logic [6:0] p, input logic [2:0] l,
                       input logic [7:0] nw);
        if (use_we) begin
            cur_pat   = p;
            cur_len   = l;
            cur_words = nw;
        end
        build_trace();
        @(negedge clk);
        start       = 1'b1;
        cfg_we      = use_we;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_words   = nw;
        in_valid    = 1'b0;
        foreach (tr[k]) begin
            @(negedge clk);
            cyc++;
            chk("in_ready", int'(in_ready), int'(tr[k].ready));
            chk("busy", int'(busy), int'(tr[k].busy));
            chk("done", int'(done), int'(tr[k].done));
            chk("match_pulse", int'(match_pulse), int'(tr[k].pulse));
            chk("match_cnt", int'(match_cnt), tr[k].cnt);
            if (k == tr.size() - 1) begin
                start    = 1'b0;
                cfg_we   = 1'b0;
                in_valid = 1'b0;
            end else begin
                // Stray start/config writes mid-run must have no effect.
                start       = 1'($urandom);
                cfg_we      = 1'($urandom);
                cfg_pattern = 7'($urandom);
                cfg_len     = 3'($urandom);
                cfg_words   = 8'($urandom);
                in_valid    = tr[k].valid;
                in_data     = tr[k].data;
            end
        end
    endtask

    initial begin
        vec[0] = '{pat: 7'b0011010, len: 3'd7, nw: 8'd1, w0: 8'b00110100, w1: 8'h00, dly: 0, exp_cnt: 1};
        vec[1] = '{pat: 7'b0011010, len: 3'd7, nw: 8'd2, w0: 8'b00000011, w1: 8'b01000000, dly: 0, exp_cnt: 1};
        vec[2] = '{pat: 7'b0000101, len: 3'd3, nw: 8'd1, w0: 8'b10101010, w1: 8'h00, dly: 2, exp_cnt: 3};
        vec[3] = '{pat: 7'b1111111, len: 3'd0, nw: 8'd2, w0: 8'hFF, w1: 8'hFF, dly: 1, exp_cnt: 10};
        vec[4] = '{pat: 7'b0000001, len: 3'd1, nw: 8'd1, w0: 8'hFF, w1: 8'h00, dly: 5, exp_cnt: 8};

        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_match_pulse", int'(match_pulse), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int w = 0; w < 64; w++) begin
                wbuf[w] = 8'h00;
                dbuf[w] = vec[i].dly;
            end
            wbuf[0] = vec[i].w0;
            wbuf[1] = vec[i].w1;
            run(1'b1, vec[i].pat, vec[i].len, vec[i].nw);
            chk("table_cnt", int'(match_cnt), vec[i].exp_cnt);
        end

        run(1'b1, 7'h55, 3'd3, 8'd0);
        chk("zero_words_cnt", int'(match_cnt), 0);

        for (int w = 0; w < 64; w++) begin
            wbuf[w] = 8'hFF;
            dbuf[w] = 0;
        end
        run(1'b1, 7'h01, 3'd1, 8'd40);
        chk("saturate_cnt", int'(match_cnt), 255);

        // Asynchronous reset in the middle of the second word's shifting.
        @(negedge clk);
        start       = 1'b1;
        cfg_we      = 1'b1;
        cfg_pattern = 7'h7F;
        cfg_len     = 3'd0;
        cfg_words   = 8'd2;
        in_valid    = 1'b1;
        in_data     = 8'hFF;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_match_pulse", int'(match_pulse), 0);
        chk("arst_match_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        cur_pat   = '0;
        cur_len   = '0;
        cur_words = '0;
        run(1'b0, 7'h7F, 3'd0, 8'd5);
        chk("post_rst_cfg_cnt", int'(match_cnt), 0);
        run(1'b1, 7'h7F, 3'd0, 8'd1);
        chk("post_rst_fresh_cnt", int'(match_cnt), 2);

        for (int r = 0; r < 40; r++) begin
            bit uw;
            for (int w = 0; w < 64; w++) begin
                wbuf[w] = 8'($urandom);
                dbuf[w] = int'($urandom_range(0, 3));
            end
            uw = (r < 2) || ($urandom_range(0, 3) != 0);
            run(uw, 7'($urandom), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Sequencing controller for a serial pattern-match datapath.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first into an internal history register.
- Compares the history against a runtime-configured pattern of 1..PAT_W bits, counts matches over a run of cfg_words words, and signals done.
- Sits between a word-oriented producer and the serial detector datapath, replacing fixed-pattern hardwired detectors.

Parameters:
- DATA_W, 8: input word width, bits serialised per word.
- PAT_W, 7: maximum pattern length, history register width.
- CNT_W, 8: width of the word-count and match-count fields.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is compared against the oldest bit.
- cfg_len  in  $clog2(PAT_W+1)  pattern length; 0 is treated as PAT_W.
- cfg_words  in  CNT_W  number of words in a run.
- start  in  1  run request.
- in_valid  in  1  producer word valid.
- in_data  in  DATA_W  producer word.
- in_ready  out  1  controller accepts a word.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle end-of-run pulse.
- match_pulse  out  1  one-cycle pulse per match.
- match_cnt  out  CNT_W  matches in the current or last run.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; history, fill, bit index, word counter and config registers cleared (cfg_len reg=0, i.e. PAT_W).
- Config: cfg_we is sampled only in IDLE and captures pattern/len/words. Writes while busy are ignored.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - in_ready=0.
  - On start: clear match_cnt, history and fill; load the word counter from the cfg_words register; go to LOAD.
  - If cfg_words==0, go to DONE instead.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1, driven combinationally from state.
  - On in_valid&&in_ready: capture in_data, bit_idx=DATA_W-1, go to SHIFT.
  - No handshake: stay in LOAD indefinitely.
- SHIFT:
  - One bit per cycle: hist <= {hist[PAT_W-2:0], word[bit_idx]}; fill saturates at PAT_W.
  - Match condition, evaluated on the post-shift history: fill_next >= L and hist_next[L-1:0] == pattern[L-1:0], where L is the effective length.
  - On match, at the same edge: match_pulse<=1 for exactly one cycle, and match_cnt increments, saturating at 2^CNT_W-1.
  - Overlapping matches count individually.
  - History persists across word boundaries within a run, so cross-word matches count.
  - At bit_idx==0: decrement the word counter; go to DONE if it reaches 0, else LOAD.
- DONE: done=1 for one cycle; go to IDLE. match_cnt holds until the next start.
- Latency: the start edge is E0. With in_valid held high, done is high in the cycle after edge E0+1+DATA_W*words+words-1. For a 1-word run at DATA_W=8, done is high after edge E9.
- Throughput: DATA_W+1 cycles per word.
- Simultaneous start and cfg_we in IDLE: the new config applies to the run being started.

Optional Feature:
- Macro: PATTERN_SCAN_ABORT_EN.
- Defined: adds input port abort (1 bit). abort high in LOAD or SHIFT forces IDLE at the next edge. done is not pulsed, match_cnt is retained, and a match pulse due at that edge is suppressed.
- Undefined: no abort port; a run ends only via DONE or rst.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - the state enum (IDLE=0, LOAD=1, SHIFT=2, DONE=3);
  - the default DATA_W/PAT_W/CNT_W constants;
  - the effective-length function (0 maps to PAT_W).
- One sub-module, pattern_match_core: history register, fill counter and length-masked comparator. Inputs: shift_en, clr, bit_in. Output: combinational match. The FSM, counters and handshake stay in the top.

Test Plan:
- Single match: pattern 7'b0011010, len 7, words 1, data 8'b00110100 -> match_pulse after the 7th shift edge; match_cnt=1; done 10 cycles after the start edge.
- Cross-word: words 2, data 8'b00000011 then 8'b01000000, pattern as above -> exactly one match, in the 3rd bit of word 2; match_cnt=1.
- Overlap with short pattern: len 3, pattern 3'b101, data 8'b10101010 -> matches at bits 3, 5, 7; match_cnt=3.
- Saturation and backpressure: CNT_W=2, len 1, pattern 1, words 1, data 8'hFF, in_valid delayed 5 cycles -> in_ready high for 5 cycles; match_cnt stops at 3 while match_pulse still fires 8 times.
- Zero words and config lock: cfg_words 0 plus start -> done the next cycle, in_ready never high. A cfg_we during a run does not change the running pattern.
- Reset mid-SHIFT: assert rst asynchronously -> all outputs 0 immediately. The next run with len 7 needs 7 fresh bits before any match.
